// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 4-bit ALU: queues {opcode, A, B}, issues one at a time, captures result.
// Optional MULT/DIV watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_opcode_i,
    input  logic [3:0] cmd_a_i,
    input  logic [3:0] cmd_b_i,
    output logic [2:0] op_code_o,
    output logic [3:0] op_a_o,
    output logic [3:0] op_b_o,
    output logic       mul_init_o,
    output logic       div_init_o,
    input  logic       mul_done_i,
    input  logic       div_done_i,
    input  logic [7:0] alu_result_i,
    output logic [7:0] result_o,
    output logic       result_valid_o,
    input  logic       result_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
    localparam int unsigned WaitW  = $clog2(CntMax + 1);

    localparam logic [2:0]    OpMult    = 3'b010;
    localparam logic [2:0]    OpDiv     = 3'b011;
    localparam logic [PtrW:0] CountFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0] CountOne  = (PtrW + 1)'(1);
    localparam logic [WaitW-1:0] SettleLast = WaitW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StHold
    } state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    // ---------------------------------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------------------------------
    cmd_t            fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    cmd_t            head;
    cmd_t            cmd_in;

    assign cmd_ready_o = (count_q != CountFull);
    assign fifo_empty  = (count_q == '0);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign head        = fifo_q[rd_ptr_q];
    assign cmd_in      = '{opcode: cmd_opcode_i, a: cmd_a_i, b: cmd_b_i};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count_q says they were written.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Issue FSM
    // ---------------------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]       op_code_q, op_code_d;
    logic [3:0]       op_a_q, op_a_d;
    logic [3:0]       op_b_q, op_b_d;
    logic [7:0]       result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             is_mult;
    logic             is_div;
    logic             done_match;
`ifdef ALU_SEQ_TIMEOUT_EN
    logic             err_q, err_d;
    localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TIMEOUT - 1);
`endif

    assign is_mult    = (op_code_q == OpMult);
    assign is_div     = (op_code_q == OpDiv);
    // Only the unit that was started can end the wait; the other done is ignored.
    assign done_match = (is_mult && mul_done_i) || (is_div && div_done_i);

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        op_code_d      = op_code_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        err_d          = err_q;
`endif
        pop            = 1'b0;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    op_code_d = head.opcode;
                    op_a_d    = head.a;
                    op_b_d    = head.b;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (is_mult || is_div) begin
                    if (done_match) begin
                        result_d       = alu_result_i;
                        result_valid_d = 1'b1;
                        state_d        = StHold;
`ifdef ALU_SEQ_TIMEOUT_EN
                    end else if (wait_cnt_q == TimeoutLast) begin
                        result_d       = 8'hFF;
                        result_valid_d = 1'b1;
                        err_d          = 1'b1;
                        state_d        = StHold;
`endif
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else if (wait_cnt_q == SettleLast) begin
                    result_d       = alu_result_i;
                    result_valid_d = 1'b1;
                    state_d        = StHold;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StHold: begin
                if (result_ready_i) begin
                    result_valid_d = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
                    err_d          = 1'b0;
`endif
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            wait_cnt_q     <= '0;
            op_code_q      <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            op_code_q      <= op_code_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Init pulses decode the registered state and opcode, so they are one cycle wide.
    assign mul_init_o     = (state_q == StIssue) && is_mult;
    assign div_init_o     = (state_q == StIssue) && is_div;
    assign op_code_o      = op_code_q;
    assign op_a_o         = op_a_q;
    assign op_b_o         = op_b_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign busy_o         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small ALU and MULT/DIV done model.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [2:0] cmd_opcode_i;
    logic [3:0] cmd_a_i;
    logic [3:0] cmd_b_i;
    logic [2:0] op_code_o;
    logic [3:0] op_a_o;
    logic [3:0] op_b_o;
    logic       mul_init_o;
    logic       div_init_o;
    logic       mul_done_i;
    logic       div_done_i;
    logic [7:0] alu_result_i;
    logic [7:0] result_o;
    logic       result_valid_o;
    logic       result_ready_i;
    logic       busy_o;
    logic       err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int mul_init_cnt = 0;
    int div_init_cnt = 0;
    int mul_cnt = 0;
    int div_cnt = 0;
    logic mul_auto = 1'b1;
    logic div_auto = 1'b1;
    logic div_force = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_opcode_i   (cmd_opcode_i),
        .cmd_a_i        (cmd_a_i),
        .cmd_b_i        (cmd_b_i),
        .op_code_o      (op_code_o),
        .op_a_o         (op_a_o),
        .op_b_o         (op_b_o),
        .mul_init_o     (mul_init_o),
        .div_init_o     (div_init_o),
        .mul_done_i     (mul_done_i),
        .div_done_i     (div_done_i),
        .alu_result_i   (alu_result_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    // Minimal ALU mux: add, mult, div (quotient zero-extended)
    always_comb begin
        alu_result_i = 8'h00;
        case (op_code_o)
            3'b000: alu_result_i = {4'h0, op_a_o} + {4'h0, op_b_o};
            3'b010: alu_result_i = {4'h0, op_a_o} * {4'h0, op_b_o};
            3'b011: alu_result_i = (op_b_o != 4'h0) ? {4'h0, op_a_o / op_b_o} : 8'h0F;
            default: alu_result_i = 8'h00;
        endcase
    end

    // Units answer with a one-cycle done a few cycles after their init pulse
    always @(negedge clk) begin
        if (mul_init_o) mul_init_cnt = mul_init_cnt + 1;
        if (div_init_o) div_init_cnt = div_init_cnt + 1;
        if (mul_init_o) mul_cnt = 5;
        else if (mul_cnt != 0) mul_cnt = mul_cnt - 1;
        if (div_init_o) div_cnt = 5;
        else if (div_cnt != 0) div_cnt = div_cnt - 1;
        mul_done_i = mul_auto && (mul_cnt == 1);
        div_done_i = div_force || (div_auto && (div_cnt == 1));
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = op;
        cmd_a_i      = a;
        cmd_b_i      = b;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_valid_o && n < max_cyc);
        check_eq(tag, {31'd0, result_valid_o}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check_eq({tag, "_rvalid"}, {31'd0, result_valid_o}, 32'd0);
        check_eq({tag, "_result"}, {24'd0, result_o}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, err_o}, 32'd0);
        check_eq({tag, "_ops"}, {21'd0, op_code_o, op_a_o, op_b_o}, 32'd0);
        check_eq({tag, "_inits"}, {30'd0, mul_init_o, div_init_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i          = 1'b1;
        cmd_valid_i    = 1'b0;
        cmd_opcode_i   = 3'b000;
        cmd_a_i        = 4'h0;
        cmd_b_i        = 4'h0;
        result_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_i = 1'b0;
        @(negedge clk);

        // 1: add latency and value
        push(3'b000, 4'd3, 4'd5);
        repeat (3) @(negedge clk);
        check_eq("add_early", {31'd0, result_valid_o}, 32'd0);
        @(negedge clk);
        check_eq("add_valid", {31'd0, result_valid_o}, 32'd1);
        check_eq("add_result", {24'd0, result_o}, 32'h08);
        check_eq("add_err", {31'd0, err_o}, 32'd0);
        check_eq("add_ops", {21'd0, op_code_o, op_a_o, op_b_o}, {21'd0, 3'b000, 4'd3, 4'd5});
        @(negedge clk);
        check_eq("add_release", {30'd0, result_valid_o, busy_o}, 32'd0);

        // 2: mult and div with done handshakes
        push(3'b010, 4'd7, 4'd6);
        mul_init_cnt = 0;
        div_init_cnt = 0;
        wait_valid("mul_valid", 40);
        check_eq("mul_result", {24'd0, result_o}, 32'h2A);
        check_eq("mul_init_once", mul_init_cnt, 32'd1);
        check_eq("mul_no_div_init", div_init_cnt, 32'd0);
        @(negedge clk);
        push(3'b011, 4'd13, 4'd4);
        mul_init_cnt = 0;
        div_init_cnt = 0;
        wait_valid("div_valid", 40);
        check_eq("div_result", {24'd0, result_o}, 32'h03);
        check_eq("div_init_once", div_init_cnt, 32'd1);
        check_eq("div_no_mul_init", mul_init_cnt, 32'd0);
        @(negedge clk);

        // 3: back-pressure with five queued adds
        result_ready_i = 1'b0;
        push(3'b000, 4'd1, 4'd1);
        push(3'b000, 4'd2, 4'd3);
        push(3'b000, 4'd4, 4'd4);
        push(3'b000, 4'd15, 4'd15);
        push(3'b000, 4'd9, 4'd6);
        check_eq("bp_full", {31'd0, cmd_ready_o}, 32'd0);
        @(negedge clk);
        check_eq("bp_r0", {23'd0, result_valid_o, result_o}, {23'd0, 1'b1, 8'h02});
        repeat (3) @(negedge clk);
        check_eq("bp_r0_hold", {23'd0, result_valid_o, result_o}, {23'd0, 1'b1, 8'h02});
        check_eq("bp_busy", {30'd0, busy_o, cmd_ready_o}, 32'd2);
        result_ready_i = 1'b1;
        wait_valid("bp_v1", 20);
        check_eq("bp_r1", {24'd0, result_o}, 32'h05);
        wait_valid("bp_v2", 20);
        check_eq("bp_r2", {24'd0, result_o}, 32'h08);
        wait_valid("bp_v3", 20);
        check_eq("bp_r3", {24'd0, result_o}, 32'h1E);
        wait_valid("bp_v4", 20);
        check_eq("bp_r4", {24'd0, result_o}, 32'h0F);
        check_eq("bp_busy_last", {31'd0, busy_o}, 32'd1);
        @(negedge clk);
        check_eq("bp_drained", {30'd0, busy_o, result_valid_o}, 32'd0);

        // 4: push on the IDLE pop edge, then fill to four
        result_ready_i = 1'b0;
        push(3'b000, 4'd1, 4'd2);
        push(3'b000, 4'd2, 4'd2);
        push(3'b000, 4'd5, 4'd5);
        push(3'b000, 4'd8, 4'd1);
        @(negedge clk);
        check_eq("sp_a", {23'd0, result_valid_o, result_o}, {23'd0, 1'b1, 8'h03});
        check_eq("sp_three", {31'd0, cmd_ready_o}, 32'd1);
        result_ready_i = 1'b1;
        @(negedge clk);
        cmd_valid_i  = 1'b1;
        cmd_opcode_i = 3'b000;
        cmd_a_i      = 4'd6;
        cmd_b_i      = 4'd7;
        @(negedge clk);
        check_eq("sp_after_pop_push", {31'd0, cmd_ready_o}, 32'd1);
        cmd_a_i = 4'd12;
        cmd_b_i = 4'd12;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check_eq("sp_full", {31'd0, cmd_ready_o}, 32'd0);
        wait_valid("sp_vb", 20);
        check_eq("sp_b", {24'd0, result_o}, 32'h04);
        wait_valid("sp_vc", 20);
        check_eq("sp_c", {24'd0, result_o}, 32'h0A);
        wait_valid("sp_vd", 20);
        check_eq("sp_d", {24'd0, result_o}, 32'h09);
        wait_valid("sp_ve", 20);
        check_eq("sp_e", {24'd0, result_o}, 32'h0D);
        wait_valid("sp_vf", 20);
        check_eq("sp_f", {24'd0, result_o}, 32'h18);
        repeat (2) @(negedge clk);
        check_eq("sp_no_dup", {30'd0, busy_o, result_valid_o}, 32'd0);

        // 5: reset while a DIV waits with two commands queued
        div_auto = 1'b0;
        push(3'b011, 4'd8, 4'd2);
        push(3'b000, 4'd1, 4'd1);
        push(3'b000, 4'd2, 4'd2);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_i     = 1'b0;
        div_force = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("late_done", {29'd0, result_valid_o, busy_o, cmd_ready_o}, 32'd1);
        div_force = 1'b0;
        div_auto  = 1'b1;
        @(negedge clk);
        push(3'b000, 4'd2, 4'd5);
        wait_valid("post_rst_v", 20);
        check_eq("post_rst_r", {24'd0, result_o}, 32'h07);
        @(negedge clk);
        check_eq("post_rst_empty", {31'd0, busy_o}, 32'd0);

`ifdef ALU_SEQ_TIMEOUT_EN
        // 6: DIV that never completes
        div_auto       = 1'b0;
        result_ready_i = 1'b0;
        push(3'b011, 4'd9, 4'd0);
        repeat (66) @(negedge clk);
        check_eq("to_early", {31'd0, result_valid_o}, 32'd0);
        @(negedge clk);
        check_eq("to_valid", {31'd0, result_valid_o}, 32'd1);
        check_eq("to_result", {24'd0, result_o}, 32'hFF);
        check_eq("to_err", {31'd0, err_o}, 32'd1);
        result_ready_i = 1'b1;
        @(negedge clk);
        check_eq("to_err_clr", {30'd0, err_o, result_valid_o}, 32'd0);
        div_force = 1'b1;
        repeat (2) @(negedge clk);
        div_force = 1'b0;
        check_eq("to_late_done", {30'd0, busy_o, result_valid_o}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
